fir_stream_ctrl: RTL and testbench
==================================

# fir_stream_ctrl

Sequencing controller for the FIR demo datapath. It generates the sample-rate tick, the waveform-ROM address and read enable, and the FIR shift strobe. On a waveform change (`rom_sel`) it flushes the FIR delay line with zero samples before restarting on the new waveform at address 0. It sits between the top-level controls (`clk`, `rst`, `rom_sel`) and the existing ROM + FIR datapath inside `fir_top`.

## Interface
- `ADDR_W`, 10: ROM address width.
- `ROM_DEPTH`, 1024: number of ROM words; address wraps at `ROM_DEPTH-1`.
- `DIV_W`, 8: width of the sample-period divider.
- `TAPS`, 16: FIR tap count; sets both the flush length and the valid threshold.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable.
- `rom_sel`  in  2  requested waveform.
- `div`  in  `DIV_W`  sample period minus 1, in clocks (0 = one sample per clock).
- `rom_sel_q`  out  2  latched waveform select driving the ROM mux.
- `rom_addr`  out  `ADDR_W`  ROM read address.
- `rom_en`  out  1  ROM read enable; ROM data is valid one cycle later.
- `fir_sample_en`  out  1  FIR delay-line shift strobe.
- `fir_zero`  out  1  with `fir_sample_en`, forces the FIR input to 0.
- `fir_out_valid`  out  1  FIR window is filled with current-waveform samples.
- `busy_flush`  out  1  high while in FLUSH.

## Operation
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- Tick: an internal counter `cnt` runs 0..`div`.
  - `tick = (cnt >= div)`; `cnt` clears on tick and on every state change.
  - Using `>=` means a mid-run decrease of `div` cannot hang the counter.
- States (encoding IDLE=00, RUN=01, FLUSH=10):
  - **IDLE**: `rom_addr`=0. When `en`=1, go to RUN and load `rom_sel_q <= rom_sel`.
  - **RUN**:
    - Tick with no select change: `rom_en`=1 on the next cycle. `rom_addr` increments on the edge where `rom_en`=1, wrapping from `ROM_DEPTH-1` to 0.
    - `fir_sample_en` pulses one cycle after `rom_en`, with `fir_zero`=0.
  - **FLUSH**:
    - Entered from RUN when `rom_sel != rom_sel_q`. On entry, `fir_out_valid` clears and `busy_flush`=1.
    - Each tick produces `fir_sample_en`=1 and `fir_zero`=1, two cycles after the tick, with no ROM read.
    - After the `TAPS`-th flush tick: go to RUN, `rom_sel_q <= rom_sel` (the value at exit), `rom_addr` <= 0, sample count <= 0.
  - `en`=0 in RUN or FLUSH: go to IDLE next cycle, `rom_addr` <= 0, `fir_out_valid` <= 0.
- Valid tracking: a sample counter of width `$clog2(TAPS+1)` counts non-zero `fir_sample_en` pulses in the current RUN segment and saturates at `TAPS`. `fir_out_valid` rises the cycle after the `TAPS`-th pulse.
- Boundary rules:
  - Select change and tick in the same cycle: the change wins and no fetch is issued.
  - An already-issued `rom_en` always completes its `fir_sample_en`, even across a state change to FLUSH or IDLE. That sample is not counted toward valid.
  - `rom_sel` changing during FLUSH does not restart the flush; only the value at exit is used.
  - `rom_sel` changing in IDLE is harmless; it is captured on start.
  - Reset mid-operation: immediate return to all-zero outputs; no pulses continue.

## Timing
- `en` rises at cycle t (from IDLE), with `div`=0:
  - RUN from t+1.
  - `rom_en` every cycle from t+2 (addr 0, 1, 2, …).
  - `fir_sample_en` from t+3.
  - `fir_out_valid` from t+3+`TAPS`.
- General `div`=D: one `rom_en` pulse per D+1 cycles.
- Select change seen at cycle s (RUN), `div`=0:
  - FLUSH at s+1.
  - Zero strobes at s+3..s+`TAPS`+2.
  - RUN at s+`TAPS`+1.
  - First new `rom_en` at s+`TAPS`+2 (addr 0).
  - First new `fir_sample_en` at s+`TAPS`+3; strobes never overlap.
- ROM read latency is fixed at 1 cycle.

## Structure
- Shared package `fir_pkg`: state encoding constants (`ST_IDLE`, `ST_RUN`, `ST_FLUSH`), `ROM_SEL_W`=2, default `TAPS`.
- One sub-module, `fir_tick_gen`: divider counter with `clr` input and `tick` output.
- FSM, address counter, sample/flush counters and output registers live in `fir_stream_ctrl`.

## Test plan
- Reset, `en`=1, `div`=0, `rom_sel`=0:
  - `rom_en` continuous from the 2nd cycle after `en`.
  - Addresses 0..1023 then wrap to 0.
  - `fir_out_valid` rises exactly 16 cycles after the first `fir_sample_en`.
- `div`=3: `rom_en` exactly once every 4 cycles; `fir_sample_en` one cycle after each.
- `rom_sel` 0→1 mid-run:
  - Exactly 16 `fir_sample_en`+`fir_zero` pulses.
  - `fir_out_valid` low throughout.
  - `rom_sel_q`=1 and restart at addr 0.
- `rom_sel` 1→2→1 during FLUSH: flush not extended; `rom_sel_q`=1 at exit.
- Select change on a tick cycle: no `rom_en` that cycle; the in-flight previous sample still strobes with `fir_zero`=0.
- Assert `rst` during FLUSH, then `en`=0 in RUN: all outputs 0 immediately on reset; after `en` drops, IDLE next cycle with `rom_addr`=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR demo sequencing logic.
package fir_pkg;

    localparam int ROM_SEL_W    = 2;
    localparam int TAPS_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

endpackage

// File: rtl/fir_tick_gen.sv
// Sample-rate divider: tick when the counter reaches div; clr restarts the period.
module fir_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a div decrease below the current count still ticks.
    assign tick = (cnt >= div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Sequencer for ROM fetch and FIR shift; flushes the delay line with zeros on a
// waveform change. Handshake-free: rom_en -> (1 cycle) -> fir_sample_en, fixed latency.
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int ROM_DEPTH = 1024,
    parameter int DIV_W     = 8,
    parameter int TAPS      = TAPS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ROM_SEL_W-1:0] rom_sel,
    input  logic [DIV_W-1:0]     div,
    output logic [ROM_SEL_W-1:0] rom_sel_q,
    output logic [ADDR_W-1:0]    rom_addr,
    output logic                 rom_en,
    output logic                 fir_sample_en,
    output logic                 fir_zero,
    output logic                 fir_out_valid,
    output logic                 busy_flush
);

    localparam int                 CNT_W     = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0]   TAPS_CNT  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0]   TAPS_M1   = CNT_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(ROM_DEPTH - 1);

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             flush_d;
    logic             tick;
    logic             sel_change;
    logic             flush_done;
    logic             state_change;
    logic             sample_count_en;

    assign sel_change = (rom_sel != rom_sel_q);
    assign flush_done = tick && (flush_cnt == TAPS_M1);

    always_comb begin
        state_change = 1'b0;
        case (state)
            ST_IDLE:  state_change = en;
            ST_RUN:   state_change = !en || sel_change;
            ST_FLUSH: state_change = !en || flush_done;
            default:  state_change = 1'b1;
        endcase
    end

    // Only strobes belonging to the current RUN segment count toward valid;
    // a strobe landing after a state change sees a non-RUN state here.
    assign sample_count_en = fir_sample_en && !fir_zero && (state == ST_RUN)
                             && (sample_cnt != TAPS_CNT);

    fir_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_change),
        .div  (div),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rom_sel_q     <= '0;
            rom_addr      <= '0;
            rom_en        <= 1'b0;
            fir_sample_en <= 1'b0;
            fir_zero      <= 1'b0;
            fir_out_valid <= 1'b0;
            busy_flush    <= 1'b0;
            sample_cnt    <= '0;
            flush_cnt     <= '0;
            flush_d       <= 1'b0;
        end else begin
            rom_en        <= 1'b0;
            flush_d       <= 1'b0;
            fir_sample_en <= rom_en || flush_d;
            fir_zero      <= flush_d;

            if (rom_en) begin
                rom_addr <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + 1'b1;
            end

            if (sample_count_en) begin
                sample_cnt <= sample_cnt + 1'b1;
                if (sample_cnt == TAPS_M1) begin
                    fir_out_valid <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    rom_addr      <= '0;
                    sample_cnt    <= '0;
                    fir_out_valid <= 1'b0;
                    busy_flush    <= 1'b0;
                    if (en) begin
                        state     <= ST_RUN;
                        rom_sel_q <= rom_sel;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state         <= ST_IDLE;
                        rom_addr      <= '0;
                        sample_cnt    <= '0;
                        fir_out_valid <= 1'b0;
                    end else if (sel_change) begin
                        state         <= ST_FLUSH;
                        sample_cnt    <= '0;
                        flush_cnt     <= '0;
                        fir_out_valid <= 1'b0;
                        busy_flush    <= 1'b1;
                    end else if (tick) begin
                        rom_en <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!en) begin
                        state         <= ST_IDLE;
                        rom_addr      <= '0;
                        sample_cnt    <= '0;
                        fir_out_valid <= 1'b0;
                        busy_flush    <= 1'b0;
                    end else if (tick) begin
                        flush_d <= 1'b1;
                        if (flush_cnt == TAPS_M1) begin
                            state      <= ST_RUN;
                            rom_sel_q  <= rom_sel;
                            rom_addr   <= '0;
                            sample_cnt <= '0;
                            busy_flush <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with hand-derived cycle-by-cycle expectations.
module tb_fir_stream_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] rom_sel;
    logic [7:0] div;
    logic [1:0] rom_sel_q;
    logic [9:0] rom_addr;
    logic       rom_en;
    logic       fir_sample_en;
    logic       fir_zero;
    logic       fir_out_valid;
    logic       busy_flush;

    int checks;
    int failures;

    fir_stream_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .rom_sel       (rom_sel),
        .div           (div),
        .rom_sel_q     (rom_sel_q),
        .rom_addr      (rom_addr),
        .rom_en        (rom_en),
        .fir_sample_en (fir_sample_en),
        .fir_zero      (fir_zero),
        .fir_out_valid (fir_out_valid),
        .busy_flush    (busy_flush)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b0;
        rom_sel = 2'd0;
        div     = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_en"},   32'(rom_en),        32'(0));
        check({tag, "_sample"},   32'(fir_sample_en), 32'(0));
        check({tag, "_zero"},     32'(fir_zero),      32'(0));
        check({tag, "_valid"},    32'(fir_out_valid), 32'(0));
        check({tag, "_busy"},     32'(busy_flush),    32'(0));
        check({tag, "_addr"},     32'(rom_addr),      32'(0));
        check({tag, "_sel_q"},    32'(rom_sel_q),     32'(0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // reset state
        do_reset();
        check_all_zero("reset");

        // div=0 continuous run, address wrap, valid threshold
        en = 1'b1;
        for (int k = 1; k <= 1030; k++) begin
            @(negedge clk);
            check("run_rom_en", 32'(rom_en),        32'(k >= 2));
            check("run_addr",   32'(rom_addr),      32'((k >= 2) ? (k - 2) % 1024 : 0));
            check("run_sample", 32'(fir_sample_en), 32'(k >= 3));
            check("run_zero",   32'(fir_zero),      32'(0));
            check("run_valid",  32'(fir_out_valid), 32'(k >= 19));
        end

        // div=3: one fetch every 4 cycles, strobe one cycle later
        do_reset();
        div = 8'd3;
        en  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("div3_rom_en", 32'(rom_en),        32'(k >= 5 && (k - 5) % 4 == 0));
            check("div3_sample", 32'(fir_sample_en), 32'(k >= 6 && (k - 6) % 4 == 0));
            check("div3_addr",   32'(rom_addr),      32'((k <= 5) ? 0 : (k - 6) / 4 + 1));
        end

        // rom_sel 0->1 on a tick cycle mid-run: in-flight strobe, 16 zero strobes, restart
        do_reset();
        en = 1'b1;
        repeat (30) @(negedge clk);
        check("pre_flush_valid", 32'(fir_out_valid), 32'(1));
        rom_sel = 2'd1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("fl_busy",   32'(busy_flush),    32'(k <= 16));
            check("fl_rom_en", 32'(rom_en),        32'(k >= 18));
            check("fl_sample", 32'(fir_sample_en), 32'(k == 1 || k >= 3));
            check("fl_zero",   32'(fir_zero),      32'(k >= 3 && k <= 18));
            check("fl_valid",  32'(fir_out_valid), 32'(k >= 35));
            check("fl_sel_q",  32'(rom_sel_q),     32'((k >= 17) ? 1 : 0));
            check("fl_addr",   32'(rom_addr),      32'((k <= 16) ? 29 : ((k <= 18) ? 0 : k - 18)));
        end

        // rom_sel 1->2->1 while flushing: flush length unchanged, exit value captured
        rom_sel = 2'd2;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check("rs_busy",   32'(busy_flush), 32'(k <= 16));
            check("rs_rom_en", 32'(rom_en),     32'(k >= 18));
            if (k >= 17) check("rs_sel_q", 32'(rom_sel_q), 32'(1));
            if (k >= 18) check("rs_addr",  32'(rom_addr),  32'(k - 18));
            if (k == 4)  rom_sel = 2'd1;
            if (k == 8)  rom_sel = 2'd2;
            if (k == 12) rom_sel = 2'd1;
        end

        // reset asserted mid-flush clears outputs immediately
        rom_sel = 2'd0;
        repeat (5) @(negedge clk);
        check("rf_busy_before", 32'(busy_flush), 32'(1));
        rst = 1'b1;
        #1;
        check_all_zero("rst_flush");
        repeat (2) @(negedge clk);
        check("rst_hold_rom_en", 32'(rom_en),        32'(0));
        check("rst_hold_sample", 32'(fir_sample_en), 32'(0));
        rst = 1'b0;

        // restart, then drop en in RUN
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check("rr_rom_en", 32'(rom_en),        32'(k >= 2));
            check("rr_valid",  32'(fir_out_valid), 32'(k >= 19));
        end
        en = 1'b0;
        @(negedge clk);
        check("off_addr",   32'(rom_addr),      32'(0));
        check("off_rom_en", 32'(rom_en),        32'(0));
        check("off_valid",  32'(fir_out_valid), 32'(0));
        check("off_busy",   32'(busy_flush),    32'(0));
        check("off_sample", 32'(fir_sample_en), 32'(1));
        check("off_zero",   32'(fir_zero),      32'(0));
        @(negedge clk);
        check("off2_sample", 32'(fir_sample_en), 32'(0));
        check("off2_rom_en", 32'(rom_en),        32'(0));
        check("off2_addr",   32'(rom_addr),      32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
